// File: rtl/game_input_conditioner_if.sv
// Button-to-command bundle between the board keys and the game controller.
// The slave side is the conditioner; the master side drives the raw keys and the gaming flag.
interface game_input_conditioner_if;
  logic [6:0] i_key_raw;
  logic       i_is_gaming;
  logic       o_right;
  logic       o_left;
  logic       o_squat;
  logic       o_defend;
  logic       o_jump;
  logic       o_attack;
  logic       o_select;
  logic [6:0] o_db_state;

  modport master (
    output i_key_raw,
    output i_is_gaming,
    input  o_right,
    input  o_left,
    input  o_squat,
    input  o_defend,
    input  o_jump,
    input  o_attack,
    input  o_select,
    input  o_db_state
  );

  modport slave (
    input  i_key_raw,
    input  i_is_gaming,
    output o_right,
    output o_left,
    output o_squat,
    output o_defend,
    output o_jump,
    output o_attack,
    output o_select,
    output o_db_state
  );
endinterface

// File: rtl/game_input_conditioner.sv
// Seven-button conditioner: two-flop sync, counter debounce, edge detect, gating and attack cooldown.
// Levels for movement/guard, one-cycle pulses for jump/attack/select.
module game_input_conditioner #(
  parameter bit          ACTIVE_LOW   = 1'b1,
  parameter int unsigned DB_CYCLES    = 500000,
  parameter int unsigned CNT_W        = 20,
  parameter int unsigned ATK_COOLDOWN = 2500000,
  parameter int unsigned CD_W         = 22
) (
  input logic                  clk,
  input logic                  rst,
  game_input_conditioner_if.slave bus
);

  localparam int NB       = 7;
  localparam int K_RIGHT  = 0;
  localparam int K_LEFT   = 1;
  localparam int K_JUMP   = 2;
  localparam int K_SQUAT  = 3;
  localparam int K_ATTACK = 4;
  localparam int K_DEFEND = 5;
  localparam int K_SELECT = 6;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CD_W-1:0]  CD_LOAD = CD_W'(ATK_COOLDOWN);

  logic [NB-1:0]    pressed;
  logic [NB-1:0]    s1;
  logic [NB-1:0]    s2;
  logic [NB-1:0]    db;
  logic [NB-1:0]    dp;
  logic [NB-1:0]    rise;
  logic [CNT_W-1:0] cnt [NB];
  logic [CD_W-1:0]  cd;
  logic             gaming;
  logic             attack_fire;

  // Polarity is normalised ahead of the synchroniser so every later stage sees 1 = pressed.
  assign pressed = ACTIVE_LOW ? ~bus.i_key_raw : bus.i_key_raw;
  assign gaming  = bus.i_is_gaming;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= pressed;
      s2 <= s1;
    end
  end

  // A new level is accepted only after DB_CYCLES consecutive disagreeing samples;
  // any sample matching the current state restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      db <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (s2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= s2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dp <= '0;
    end else begin
      dp <= db;
    end
  end

  assign rise        = db & ~dp;
  assign attack_fire = rise[K_ATTACK] & gaming & (cd == '0);

  // Leaving play clears the cooldown so the first attack after re-entry is never swallowed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cd <= '0;
    end else if (!gaming) begin
      cd <= '0;
    end else if (attack_fire) begin
      cd <= CD_LOAD;
    end else if (cd != '0) begin
      cd <= cd - CD_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.o_right  <= 1'b0;
      bus.o_left   <= 1'b0;
      bus.o_squat  <= 1'b0;
      bus.o_defend <= 1'b0;
      bus.o_jump   <= 1'b0;
      bus.o_attack <= 1'b0;
      bus.o_select <= 1'b0;
    end else begin
      bus.o_right  <= db[K_RIGHT] & ~db[K_LEFT] & gaming;
      bus.o_left   <= db[K_LEFT] & ~db[K_RIGHT] & gaming;
      bus.o_squat  <= db[K_SQUAT] & gaming;
      bus.o_defend <= db[K_DEFEND] & gaming;
      bus.o_jump   <= rise[K_JUMP] & gaming;
      bus.o_attack <= attack_fire;
      bus.o_select <= rise[K_SELECT];
    end
  end

  assign bus.o_db_state = db;

endmodule

// File: tb/tb_game_input_conditioner.sv
// Randomised and directed bench for game_input_conditioner against a window-based behavioural model.
module tb_game_input_conditioner;
  localparam int DB = 4;
  localparam int CD = 10;

  logic clk = 1'b0;
  logic rst = 1'b0;

  game_input_conditioner_if bus();

  game_input_conditioner #(
    .ACTIVE_LOW  (1'b1),
    .DB_CYCLES   (DB),
    .CNT_W       (3),
    .ATK_COOLDOWN(CD),
    .CD_W        (4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [13:0] act, input logic [13:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, required %h", name, $time, act, exp);
    end
  endtask

  // Model: pressed samples history; hist[2+j] is what the debouncer saw j edges ago.
  logic [6:0] hist [DB+2];
  logic [6:0] mdb, mdp, mrise, ndb, pr;
  logic       m_right, m_left, m_squat, m_defend, m_jump, m_attack, m_select;
  logic       g, flip, cd_act;
  int         edge_n, last_att;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < DB + 2; j++) hist[j] = '0;
      mdb = '0; mdp = '0;
      {m_right, m_left, m_squat, m_defend, m_jump, m_attack, m_select} = '0;
      cd_act = 1'b0; edge_n = 0; last_att = 0;
    end else begin
      pr = ~bus.i_key_raw;
      g  = bus.i_is_gaming;
      edge_n++;
      for (int j = DB + 1; j > 0; j--) hist[j] = hist[j-1];
      hist[0] = pr;
      mrise    = mdb & ~mdp;
      m_right  = mdb[0] & ~mdb[1] & g;
      m_left   = mdb[1] & ~mdb[0] & g;
      m_squat  = mdb[3] & g;
      m_defend = mdb[5] & g;
      m_jump   = mrise[2] & g;
      m_select = mrise[6];
      m_attack = mrise[4] & g & (!cd_act || (edge_n - last_att > CD));
      if (!g) cd_act = 1'b0;
      else if (m_attack) begin
        cd_act   = 1'b1;
        last_att = edge_n;
      end
      ndb = mdb;
      for (int i = 0; i < 7; i++) begin
        flip = 1'b1;
        for (int j = 0; j < DB; j++) if (hist[2+j][i] == mdb[i]) flip = 1'b0;
        if (flip) ndb[i] = ~mdb[i];
      end
      mdp = mdb;
      mdb = ndb;
    end
  end

  function automatic logic [13:0] dut_outs();
    return {bus.o_db_state, bus.o_select, bus.o_attack, bus.o_jump, bus.o_defend,
            bus.o_squat, bus.o_left, bus.o_right};
  endfunction

  bit chk_en = 1'b0;
  always @(negedge clk) begin
    if (chk_en)
      check("model", dut_outs(),
            {mdb, m_select, m_attack, m_jump, m_defend, m_squat, m_left, m_right});
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic settle();
    bus.i_key_raw = 7'h7f;
    tick(12);
  endtask

  logic [6:0] rk;

  initial begin
    bus.i_key_raw   = 7'h7f;
    bus.i_is_gaming = 1'b1;
    #1 rst = 1'b1;
    tick(2);
    rst = 1'b0;
    chk_en = 1'b1;
    tick(1);
    check("reset_state", dut_outs(), 14'd0);

    // select press: pulse after edge 7 only
    bus.i_key_raw = 7'h3f;
    tick(6); check("sel_e6", {13'd0, bus.o_select}, 14'd0);
    tick(1); check("sel_e7", {13'd0, bus.o_select}, 14'd1);
    check("sel_db", {7'd0, bus.o_db_state}, 14'h40);
    tick(1); check("sel_e8", {13'd0, bus.o_select}, 14'd0);
    settle();

    // 3-cycle glitch on right is rejected
    bus.i_key_raw = 7'h7e;
    tick(3);
    bus.i_key_raw = 7'h7f;
    tick(10);
    check("glitch_db", {7'd0, bus.o_db_state}, 14'd0);
    check("glitch_right", {13'd0, bus.o_right}, 14'd0);

    // right+left cancel, then release left
    bus.i_key_raw = 7'h7c;
    tick(10);
    check("rl_both", {12'd0, bus.o_left, bus.o_right}, 14'd0);
    check("rl_db", {7'd0, bus.o_db_state}, 14'h03);
    bus.i_key_raw = 7'h7e;
    tick(6); check("rl_e6", {13'd0, bus.o_right}, 14'd0);
    tick(1); check("rl_e7", {13'd0, bus.o_right}, 14'd1);
    settle();

    // attack cooldown: pulse, drop within window, accept after it
    bus.i_key_raw = 7'h6f;
    tick(4);
    bus.i_key_raw = 7'h7f;
    tick(3); check("atk1", {13'd0, bus.o_attack}, 14'd1);
    tick(1);
    bus.i_key_raw = 7'h6f;
    tick(7); check("atk2_dropped", {13'd0, bus.o_attack}, 14'd0);
    check("atk2_db", {7'd0, bus.o_db_state}, 14'h10);
    bus.i_key_raw = 7'h7f;
    tick(8);
    bus.i_key_raw = 7'h6f;
    tick(6); check("atk3_e6", {13'd0, bus.o_attack}, 14'd0);
    tick(1); check("atk3_e7", {13'd0, bus.o_attack}, 14'd1);
    settle();

    // squat gated by i_is_gaming
    bus.i_is_gaming = 1'b0;
    bus.i_key_raw   = 7'h77;
    tick(10);
    check("squat_off", {13'd0, bus.o_squat}, 14'd0);
    check("squat_db", {7'd0, bus.o_db_state}, 14'h08);
    bus.i_is_gaming = 1'b1;
    tick(1); check("squat_on", {13'd0, bus.o_squat}, 14'd1);
    bus.i_is_gaming = 1'b0;
    tick(1); check("squat_drop", {13'd0, bus.o_squat}, 14'd0);
    bus.i_is_gaming = 1'b1;
    settle();

    // reset while jump held, re-debounce after release
    bus.i_key_raw = 7'h7b;
    tick(7); check("jump1", {13'd0, bus.o_jump}, 14'd1);
    tick(3); check("jump_db", {7'd0, bus.o_db_state}, 14'h04);
    rst = 1'b1;
    #1 check("rst_async", dut_outs(), 14'd0);
    tick(2);
    rst = 1'b0;
    tick(6); check("jump_rst_e6", {13'd0, bus.o_jump}, 14'd0);
    tick(1); check("jump_rst_e7", {13'd0, bus.o_jump}, 14'd1);
    tick(1); check("jump_rst_e8", {13'd0, bus.o_jump}, 14'd0);
    settle();

    // random phase: the per-cycle model compare does the checking
    rk = 7'h7f;
    for (int it = 0; it < 600; it++) begin
      rk = rk ^ (7'($urandom) & 7'($urandom));
      bus.i_key_raw = rk;
      if ($urandom_range(0, 7) == 0) bus.i_is_gaming = ~bus.i_is_gaming;
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
      end
      tick($urandom_range(1, 9));
    end
    settle();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
